uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: clk_speed, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter: baudrate, default 921600, serial bit rate in bits/s.
REQ-003 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_rx  input  1  asynchronous serial line, idle high, 8N1 frames, LSB first.
REQ-006 o_data  output  8  received byte, stable while o_valid is high.
REQ-007 o_valid  output  1  o_data holds an unconsumed byte.
REQ-008 i_ready  input  1  consumer accepts o_data in any cycle where o_valid and i_ready are both high.
REQ-009 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 o_overrun  output  1  one-cycle pulse: completed byte dropped because the buffer was full.
REQ-011 o_busy  output  1  high in any state other than IDLE.

Function
REQ-012 BIT_CYC = clk_speed / baudrate (integer division; 108 at defaults); HALF_CYC = BIT_CYC / 2 (54).
REQ-013 Bit-timer counter width SHALL be $clog2(BIT_CYC); the counter clears on every state change.
REQ-014 i_rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-015 States: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START when rx_s is low; counter starts at 0.
REQ-017 START: at count HALF_CYC-1, rx_s low -> DATA; rx_s high -> IDLE (glitch rejected, no flag).
REQ-018 DATA: at count BIT_CYC-1, shift rx_s into bit index 0..7 (LSB first); after bit 7 -> STOP.
REQ-019 STOP: at count BIT_CYC-1, sample rx_s and return to IDLE in the same edge.
REQ-020 Stop sample high: byte completes; stop sample low: o_frame_err pulses for 1 cycle, byte discarded, o_valid unchanged.
REQ-021 Byte completion, buffer empty or i_ready high in that cycle: o_data loads, o_valid is high from the next cycle, no overrun.
REQ-022 Byte completion while o_valid high and i_ready low: new byte dropped, o_data/o_valid unchanged, o_overrun pulses 1 cycle.
REQ-023 o_valid clears the cycle after a handshake unless REQ-021 reloads it in the same cycle.
REQ-024 Latency: o_valid rises exactly 1 cycle after the stop-bit sample edge.
REQ-025 A line held low after a frame-error stop SHALL be treated as a new start bit (re-enter START from IDLE).
REQ-026 The receiver SHALL never stall on i_ready; line sampling continues regardless of buffer state.

Reset
REQ-027 While i_rst_n is low: state IDLE, counter 0, bit index 0, shift register 0, synchronizer flops 1.
REQ-028 Outputs during reset: o_data 8'h00, o_valid 0, o_frame_err 0, o_overrun 0, o_busy 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no flag; reception resumes from the first falling edge after release.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum (IDLE, START, DATA, STOP) and localparam DATA_BITS = 8.
REQ-031 The synchronizer SHALL be a separate sub-module sync_2ff (reset value 1, async active-low reset); all other logic stays in uart_rx.
REQ-032 uart_rx SHALL NOT instantiate the baud tick generator; it owns its own bit timer derived from REQ-012.

Verification (defaults, 108 cycles/bit)
REQ-033 Frame 0xA5 with stop 1, i_ready high -> o_data 8'hA5, o_valid high for 1 cycle, o_valid rising 1 cycle after the stop sample.
REQ-034 i_rx low pulse of 20 cycles from idle -> return to IDLE, o_busy falls, no o_valid, no flags.
REQ-035 Frame 0x3C with stop bit 0 -> o_frame_err 1-cycle pulse, o_valid stays 0.
REQ-036 i_ready held low, frames 0x11 then 0x22 -> o_data 8'h11 retained, o_overrun pulses at the second completion; then i_ready high -> 8'h11 consumed, o_valid 0.
REQ-037 i_ready asserted in the exact completion cycle of 0x22 while 0x11 pending -> 0x11 consumed, o_data 8'h22, o_valid stays high, no o_overrun.
REQ-038 i_rst_n low during bit 4 of a frame, released mid-frame -> all outputs at reset values; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver.
//   state_t   : receiver FSM states
//   DATA_BITS : payload bits per frame (8N1)
//   calc_bit_cyc : clock cycles per serial bit (integer division)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS = 8;

  function automatic int calc_bit_cyc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous bit.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset; both flops reset to 1
//             (the idle level of a UART line)
//   i_d     : asynchronous input
//   o_q     : synchronized output, two cycles of latency
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b1;
      o_q  <= 1'b1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with a one-entry output buffer.
//   i_clk       : sole clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_rx        : asynchronous serial line, idle high, LSB first
//   o_data      : received byte, stable while o_valid is high
//   o_valid     : o_data holds an unconsumed byte
//   i_ready     : consumer accepts o_data
//   o_frame_err : one-cycle pulse, stop bit sampled low (byte discarded)
//   o_overrun   : one-cycle pulse, completed byte dropped (buffer full)
//   o_busy      : receiver is not IDLE
//   o_state     : current FSM state, for observation
//
// Handshake: a byte transfers in every cycle where o_valid and i_ready are
// both high. o_valid, once high, stays high with o_data stable until that
// transfer happens. The receiver never waits for the consumer: a byte
// completing while the buffer is still full is dropped and flagged.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_speed = 100_000_000,
  parameter int baudrate  = 921600
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy,
  output state_t     o_state
);

  localparam int BIT_CYC  = calc_bit_cyc(clk_speed, baudrate);
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_q;

  logic cnt_clr;
  logic bit_take;
  logic stop_take;
  logic byte_done;
  logic frame_bad;
  logic buf_load;
  logic buf_drop;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // Next-state and strobe decode. START waits half a bit so that every
  // later sample lands in the middle of its bit period.
  always_comb begin
    state_next = state;
    bit_take   = 1'b0;
    stop_take  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          bit_take = 1'b1;
          if (bit_idx == IDX_LAST) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          stop_take  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The bit timer restarts on every state change and at each data sample,
  // so DATA bits are spaced exactly BIT_CYC apart.
  always_comb begin
    cnt_clr   = (state_next != state) || bit_take || (state == IDLE);
    byte_done = stop_take && rx_s;
    frame_bad = stop_take && !rx_s;
    buf_load  = byte_done && (!o_valid || i_ready);
    buf_drop  = byte_done && o_valid && !i_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift_q <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state_next != DATA) bit_idx <= '0;
      else if (bit_take)      bit_idx <= bit_idx + 1'b1;
      if (bit_take) shift_q[bit_idx] <= rx_s;
    end
  end

  // Output buffer. A byte arriving in the same cycle the old one is taken
  // replaces it directly, keeping o_valid high without a gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= frame_bad;
      o_overrun   <= buf_drop;
      if (buf_load) begin
        o_data  <= shift_q;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT = 108;
  localparam int FRAME_CYC = 10 * BIT;
  localparam int DONE_CYC = 1029;  // 3 (sync + detect) + 54 + 8*108 + 108

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic i_rx;
  logic i_ready;
  logic [7:0] o_data;
  logic o_valid, o_frame_err, o_overrun, o_busy;
  state_t o_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy),
    .o_state     (o_state)
  );

  // ---------------- monitor ----------------
  int n_asserts = 0;
  int n_fail = 0;
  int fe_rises = 0, fe_cycles = 0, ov_rises = 0, ov_cycles = 0, valid_cycles = 0;
  int valid_rise_cyc = 0, busy_fall_cyc = 0;
  logic fe_prev = 0, ov_prev = 0, valid_prev = 0, busy_prev = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_frame_err) begin
        fe_cycles <= fe_cycles + 1;
        if (!fe_prev) fe_rises <= fe_rises + 1;
      end
      if (o_overrun) begin
        ov_cycles <= ov_cycles + 1;
        if (!ov_prev) ov_rises <= ov_rises + 1;
      end
      if (o_valid) valid_cycles <= valid_cycles + 1;
      if (o_valid && !valid_prev) valid_rise_cyc <= cyc;
      if (!o_busy && busy_prev) busy_fall_cyc <= cyc;
      if (o_valid && i_ready) got_q.push_back(o_data);
      fe_prev    <= o_frame_err;
      ov_prev    <= o_overrun;
      valid_prev <= o_valid;
      busy_prev  <= o_busy;
    end else begin
      fe_prev    <= 1'b0;
      ov_prev    <= 1'b0;
      valid_prev <= 1'b0;
      busy_prev  <= 1'b0;
    end
  end

  // ---------------- checks / drivers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((got_q.size() > 0 || exp_q.size() > 0) && guard < 16) begin
      guard++;
      if (got_q.size() == 0) begin
        check({name, "_missing"}, 32'(exp_q.pop_front()), 32'hFFFF_FFFF);
      end else if (exp_q.size() == 0) begin
        check({name, "_extra"}, 32'(got_q.pop_front()), 32'hFFFF_FFFF);
      end else begin
        check({name, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    i_rx = 1'b1;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  // Drives one full frame; i_rx first falls just after the posedge whose
  // cycle count is returned in t0. Optionally pulses i_ready for exactly
  // the cycle ending at the stop-sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic rdy_at_done, output int t0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t0 = 0;
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(posedge clk); #1;
      if (c == 0) t0 = cyc;
      i_rx = bits[c / BIT];
      if (rdy_at_done && c == DONE_CYC - 1) i_ready = 1'b1;
      if (rdy_at_done && c == DONE_CYC) i_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_fe;
    int         exp_acc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t0, fe0, fc0, ov0, oc0, vc0;

    vecs[0] = '{8'hA5, 1'b1, 0, 1};
    vecs[1] = '{8'h00, 1'b1, 0, 1};
    vecs[2] = '{8'hFF, 1'b1, 0, 1};
    vecs[3] = '{8'h3C, 1'b0, 1, 0};
    vecs[4] = '{8'h81, 1'b1, 0, 1};
    vecs[5] = '{8'h7E, 1'b0, 1, 0};

    // reset state
    rst_n = 1'b0; i_rx = 1'b1; i_ready = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("rst_data", 32'(o_data), 32'h00);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_fe", 32'(o_frame_err), 0);
    check("rst_ov", 32'(o_overrun), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_state", 32'(o_state), 32'(IDLE));
    @(posedge clk); #1 rst_n = 1'b1;
    idle(10);

    // 0xA5 latency: o_valid rises one cycle after the stop-sample edge
    i_ready = 1'b1;
    vc0 = valid_cycles;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    idle(20);
    check("a5_latency", 32'(valid_rise_cyc - t0), 32'(DONE_CYC));
    check("a5_busy_fall", 32'(busy_fall_cyc), 32'(valid_rise_cyc));
    check("a5_valid_width", 32'(valid_cycles - vc0), 1);
    drain("a5");

    // table vectors, consumer always ready
    foreach (vecs[i]) begin
      i_ready = 1'b1;
      fe0 = fe_rises; fc0 = fe_cycles; ov0 = ov_rises; vc0 = valid_cycles;
      if (vecs[i].exp_acc != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, 1'b0, t0);
      idle(30);
      check($sformatf("vec%0d_fe", i), 32'(fe_rises - fe0), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_fe_width", i), 32'(fe_cycles - fc0), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_ov", i), 32'(ov_rises - ov0), 0);
      check($sformatf("vec%0d_valid", i), 32'(valid_cycles - vc0), 32'(vecs[i].exp_acc));
      check($sformatf("vec%0d_busy", i), 32'(o_busy), 0);
      drain($sformatf("vec%0d", i));
    end

    // 20-cycle low glitch is rejected
    fe0 = fe_rises; ov0 = ov_rises; vc0 = valid_cycles;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      i_rx = (c < 20) ? 1'b0 : 1'b1;
      if (c == 10) check("glitch_busy_hi", 32'(o_busy), 1);
    end
    check("glitch_busy_lo", 32'(o_busy), 0);
    check("glitch_state", 32'(o_state), 32'(IDLE));
    check("glitch_flags", 32'((fe_rises - fe0) + (ov_rises - ov0)), 0);
    check("glitch_valid", 32'(valid_cycles - vc0), 0);

    // overrun: 0x11 held, 0x22 dropped
    i_ready = 1'b0;
    ov0 = ov_rises; oc0 = ov_cycles;
    send_frame(8'h11, 1'b1, 1'b0, t0);
    idle(20);
    check("ovr_first_valid", 32'(o_valid), 1);
    check("ovr_first_data", 32'(o_data), 32'h11);
    send_frame(8'h22, 1'b1, 1'b0, t0);
    idle(20);
    check("ovr_pulse", 32'(ov_rises - ov0), 1);
    check("ovr_width", 32'(ov_cycles - oc0), 1);
    check("ovr_data_kept", 32'(o_data), 32'h11);
    check("ovr_valid_kept", 32'(o_valid), 1);
    exp_q.push_back(8'h11);
    i_ready = 1'b1;
    @(posedge clk); #1 i_ready = 1'b0;
    idle(3);
    check("ovr_drained", 32'(o_valid), 0);
    drain("ovr");

    // consumer accepts exactly in the completion cycle of the second byte
    i_ready = 1'b0;
    ov0 = ov_rises;
    send_frame(8'h11, 1'b1, 1'b0, t0);
    idle(20);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 1'b1, t0);
    check("same_cyc_ov", 32'(ov_rises - ov0), 0);
    check("same_cyc_valid", 32'(o_valid), 1);
    check("same_cyc_data", 32'(o_data), 32'h22);
    i_ready = 1'b1;
    @(posedge clk); #1 i_ready = 1'b0;
    idle(3);
    check("same_cyc_drained", 32'(o_valid), 0);
    drain("same_cyc");

    // frame error then line held low: the low level is a new start bit
    i_ready = 1'b1;
    fe0 = fe_rises; vc0 = valid_cycles;
    exp_q.push_back(8'h5A);
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    send_frame(8'h5A, 1'b1, 1'b0, t0);
    idle(30);
    check("held_low_fe", 32'(fe_rises - fe0), 1);
    check("held_low_valid", 32'(valid_cycles - vc0), 1);
    drain("held_low");

    // reset during bit 4 of a frame (leave a pending byte so o_data is nonzero)
    i_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0, t0);
    idle(20);
    check("pre_rst_valid", 32'(o_valid), 1);
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'hF0, 1'b0};
      for (int c = 0; c < FRAME_CYC; c++) begin
        @(posedge clk); #1;
        i_rx = bits[c / BIT];
        if (c == 4 * BIT + 50) rst_n = 1'b0;
        if (c == 5 * BIT + 50) rst_n = 1'b1;
        if (c == 5 * BIT) begin
          check("midrst_data", 32'(o_data), 32'h00);
          check("midrst_valid", 32'(o_valid), 0);
          check("midrst_flags", 32'({o_frame_err, o_overrun}), 0);
          check("midrst_busy", 32'(o_busy), 0);
        end
      end
    end
    fe0 = fe_rises; ov0 = ov_rises; vc0 = valid_cycles;
    idle(20);
    check("postrst_busy", 32'(o_busy), 0);
    check("postrst_valid", 32'(o_valid), 0);
    i_ready = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, t0);
    idle(20);
    check("postrst_flags", 32'((fe_rises - fe0) + (ov_rises - ov0)), 0);
    check("postrst_valid_width", 32'(valid_cycles - vc0), 1);
    drain("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
